// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_sel_e;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Sign-extend a loaded byte to a full word (lb).
  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory command/response wires.
// Latency: n/a (wires only).
// Backpressure: requesters hold req and fields until their gnt; responses are single-cycle pulses.
interface mem_port_arbiter_if;

  // fetch requester
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  // load/store requester
  logic        d_req;
  logic        d_we;
  logic        d_byte;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  // memory side
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_byte, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // requesters plus memory, seen from outside the arbiter
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_byte, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_byte_lane.sv
// byte_lane_unit: byte enables and store replication for sb, lane select plus sign extension for lb.
// Latency: purely combinational.
// Backpressure: none.
module byte_lane_unit
  import mem_arb_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic        byte_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0] lane;

  // Word accesses pass through; byte accesses use little-endian lane addr_i.
  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    lane    = 8'h00;
    case (addr_i)
      2'd0:    lane = rdata_i[7:0];
      2'd1:    lane = rdata_i[15:8];
      2'd2:    lane = rdata_i[23:16];
      default: lane = rdata_i[31:24];
    endcase
    if (byte_i) begin
      be_o    = 4'b0001 << addr_i;
      wdata_o = {4{wdata_i[7:0]}};
      rdata_o = sext8(lane);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and load/store, data port first
//   (define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX data grants).
// Latency: gnt cycle 0, mem_en cycle 1, rvalid cycle MEM_LAT+2; one access per MEM_LAT+3 cycles.
// Backpressure: requests wait with gnt low until IDLE; responses are one-cycle pulses, not stallable.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);

  localparam int              LW       = $clog2(MEM_LAT + 1);
  localparam logic [LW-1:0]   LAT_INIT = LW'(MEM_LAT);
  localparam logic [LW-1:0]   LAT_LAST = LW'(1);

  arb_state_e      state_q, state_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            gnt_if, gnt_dp;
  logic            fetch_first;
  logic            last_wait;

  // fields of the access in flight
  port_sel_e       port_q;
  logic            we_q;
  logic            byte_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;

  logic [3:0]      lane_be;
  logic [31:0]     lane_wdata;
  logic [31:0]     lane_rdata;

  // Next state and combinational grant; grants only in IDLE and never while reset is asserted.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    gnt_if  = 1'b0;
    gnt_dp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n) begin
          if (bus.d_req && !(fetch_first && bus.if_req)) begin
            gnt_dp  = 1'b1;
            state_d = ACCESS;
          end else if (bus.if_req) begin
            gnt_if  = 1'b1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        state_d = WAIT;
        lat_d   = LAT_INIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latency counter registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Capture the winner's fields at the grant edge; fetch is always a word read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q  <= PORT_IF;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (gnt_dp) begin
      port_q  <= PORT_D;
      we_q    <= bus.d_we;
      byte_q  <= bus.d_byte;
      addr_q  <= bus.d_addr;
      wdata_q <= bus.d_wdata;
    end else if (gnt_if) begin
      port_q  <= PORT_IF;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= bus.if_addr;
      wdata_q <= '0;
    end
  end

  assign last_wait = (state_q == WAIT) && (lat_q == LAT_LAST);

  // Register processed read data in the last WAIT cycle; writes complete with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (last_wait) begin
      rdata_q <= we_q ? 32'h0 : lane_rdata;
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  // Count data grants that bypassed a waiting fetch; any fetch grant clears the count.
  always_comb begin
    starve_d = starve_q;
    if (gnt_if) begin
      starve_d = '0;
    end else if (gnt_dp && bus.if_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign fetch_first = (starve_q == STARVE_LIM);
`else
  // Strict data priority: STARVE_MAX has no effect and folds to a constant false.
  assign fetch_first = (STARVE_MAX < 0);
`endif

  byte_lane_unit u_lane (
    .addr_i  (addr_q[1:0]),
    .byte_i  (byte_q),
    .wdata_i (wdata_q),
    .rdata_i (bus.mem_rdata),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_dp;

  // Memory command is decoded from state so it drops the instant reset asserts.
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = bus.mem_en & we_q;
  assign bus.mem_be    = bus.mem_en ? lane_be : 4'b0000;
  assign bus.mem_addr  = addr_q[31:2];
  assign bus.mem_wdata = lane_wdata;

  assign bus.if_rvalid = (state_q == RESP) && (port_q == PORT_IF);
  assign bus.d_rvalid  = (state_q == RESP) && (port_q == PORT_D);
  assign bus.if_rdata  = bus.if_rvalid ? rdata_q : 32'h0;
  assign bus.d_rdata   = bus.d_rvalid  ? rdata_q : 32'h0;

  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model and response scoreboard.
// Latency: responses are expected exactly MEM_LAT+2 cycles after their grant.
// Backpressure: requests are held until gnt, bounded by a cycle budget.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] mem     [0:1023];
  logic [31:0] pipe    [1:MEM_LAT];
  bit          mem_loaded = 1'b0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      'h10:    return 32'h8C220004;
      'h11:    return 32'h00000013;
      'h40:    return 32'h80000000;
      default: return 32'h0;
    endcase
  endfunction

  // Memory model: write at the command edge, read data valid MEM_LAT cycles after it.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem[bus.mem_addr[9:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    pipe[1] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[9:0]] : 32'hDEADBEEF;
    for (int s = 2; s <= MEM_LAT; s++) pipe[s] <= pipe[s-1];
  end

  assign bus.mem_rdata = pipe[MEM_LAT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input bit byt);
    logic [31:0] w;
    logic [7:0]  b;
    w = ref_mem[a[11:2]];
    b = w[8*a[1:0] +: 8];
    return byt ? {{24{b[7]}}, b} : w;
  endfunction

  task automatic ref_write(input logic [31:0] a, input bit byt, input logic [31:0] wd);
    if (byt) ref_mem[a[11:2]][8*a[1:0] +: 8] = wd[7:0];
    else     ref_mem[a[11:2]] = wd;
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.if_rvalid || bus.d_rvalid)) begin
      check("one_rvalid", {31'b0, bus.if_rvalid & bus.d_rvalid}, 32'h0);
      check("rsp_pending", {31'b0, sb_q.size() > 0}, 32'h1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rsp_port", {31'b0, bus.d_rvalid}, {31'b0, e.is_d});
        check("rsp_data", e.is_d ? bus.d_rdata : bus.if_rdata, e.data);
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // One complete request: drive, wait for gnt, queue the response, check the memory command.
  task automatic issue(input bit is_d, input bit we, input bit byt,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bit          got;
    int          g;
    logic [31:0] ed;
    @(posedge clk); #1;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_byte = byt; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = is_d ? bus.d_gnt : bus.if_gnt;
    end
    check("gnt_seen", {31'b0, got}, 32'h1);
    g = cyc;
    if (we) begin
      ed = 32'h0;
      ref_write(addr, byt, wdata);
    end else begin
      ed = ref_load(addr, byt);
    end
    sb_q.push_back('{is_d, ed, g + MEM_LAT + 2});
    @(posedge clk); #1;
    if (is_d) bus.d_req = 1'b0;
    else      bus.if_req = 1'b0;
    @(negedge clk);
    check("mem_en", {31'b0, bus.mem_en}, 32'h1);
    check("mem_we", {31'b0, bus.mem_we}, {31'b0, we});
    check("mem_addr", {2'b0, bus.mem_addr}, {2'b0, addr[31:2]});
    check("mem_be", {28'b0, bus.mem_be}, byt ? {28'b0, 4'b0001 << addr[1:0]} : 32'hF);
    if (we) check("mem_wdata", bus.mem_wdata, byt ? {4{wdata[7:0]}} : wdata);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb_q.size() > 0; k++) @(negedge clk);
    check("drain", sb_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int g, n_if, n_d, ngr;
    bit fifth_if;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_byte = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // reset state, with a request pending to show gnt stays low
    repeat (2) @(posedge clk);
    #1 bus.d_req = 1'b1;
    @(negedge clk);
    check("rst_d_gnt", {31'b0, bus.d_gnt}, 32'h0);
    check("rst_if_gnt", {31'b0, bus.if_gnt}, 32'h0);
    check("rst_mem_en", {31'b0, bus.mem_en}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_rvalid", {30'b0, bus.if_rvalid, bus.d_rvalid}, 32'h0);
    check("rst_mem_be", {28'b0, bus.mem_be}, 32'h0);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    rst_n = 1'b1;

    // single fetch
    issue(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    drain();

    // simultaneous requests: data wins, fetch waits for the next IDLE
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_byte = 1'b0; bus.d_addr = 32'h100;
    @(negedge clk);
    check("sim_d_gnt", {31'b0, bus.d_gnt}, 32'h1);
    check("sim_if_gnt_lose", {31'b0, bus.if_gnt}, 32'h0);
    g = cyc;
    sb_q.push_back('{1'b1, ref_load(32'h100, 1'b0), g + MEM_LAT + 2});
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    check("sim_busy", {31'b0, busy}, 32'h1);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = bus.if_gnt;
    end
    check("sim_if_gnt_cycle", cyc, g + MEM_LAT + 3);
    sb_q.push_back('{1'b0, ref_load(32'h44, 1'b0), cyc + MEM_LAT + 2});
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    drain();

    // byte loads and stores
    issue(1'b1, 1'b0, 1'b1, 32'h103, 32'h0);
    issue(1'b1, 1'b1, 1'b1, 32'h103, 32'h000000AB);
    issue(1'b1, 1'b0, 1'b1, 32'h103, 32'h0);
    issue(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    drain();

    // word store / load round trip, then a positive byte
    issue(1'b1, 1'b1, 1'b0, 32'h200, 32'h12345678);
    issue(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    issue(1'b1, 1'b0, 1'b1, 32'h201, 32'h0);
    issue(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    drain();

    // both requesters held for 100 cycles
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_byte = 1'b0; bus.d_addr = 32'h200;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    n_if = 0; n_d = 0; ngr = 0; fifth_if = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.d_gnt) begin
        ngr++; n_d++;
        sb_q.push_back('{1'b1, ref_load(32'h200, 1'b0), cyc + MEM_LAT + 2});
      end
      if (bus.if_gnt) begin
        ngr++; n_if++;
        if (ngr == 5) fifth_if = 1'b1;
        sb_q.push_back('{1'b0, ref_load(32'h40, 1'b0), cyc + MEM_LAT + 2});
      end
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    check("starve_total_grants", ngr, 32'd20);
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve_5th_is_fetch", {31'b0, fifth_if}, 32'h1);
    check("starve_if_grants", n_if, 32'd4);
`else
    check("starve_no_if_gnt", n_if, 32'd0);
    check("starve_d_grants", n_d, 32'd20);
`endif
    drain();

    // reset during WAIT abandons the access
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_byte = 1'b0; bus.d_addr = 32'h100;
    @(negedge clk);
    check("rw_d_gnt", {31'b0, bus.d_gnt}, 32'h1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    check("rw_busy_before", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rw_mem_en", {31'b0, bus.mem_en}, 32'h0);
    check("rw_busy", {31'b0, busy}, 32'h0);
    check("rw_rvalid", {30'b0, bus.if_rvalid, bus.d_rvalid}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
